// File: rtl/de0_rstseq.sv
// Reset / clock-enable sequencer downstream of the DE0 PLL wrapper.
// Holds the PLL in reset, qualifies its lock, releases the system reset
// and generates the Z80 clock-enable strobe; any lock failure restarts it.
module de0_rstseq #(
    parameter int unsigned PLL_RST_CYC  = 16,
    parameter int unsigned LOCK_STABLE  = 256,
    parameter int unsigned LOCK_TIMEOUT = 65536,
    parameter int unsigned HOLD_CYC     = 64,
    parameter int unsigned CE_DIV       = 14
) (
    input  logic       clkin,
    input  logic       rst_n,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       cpu_ce,
    output logic       ready,
    output logic [7:0] fail_cnt
);

    // cnt is shared between PLL_RST and HOLD, so it is sized for the longer one
    localparam int unsigned CNT_MAX = (PLL_RST_CYC > HOLD_CYC) ? PLL_RST_CYC : HOLD_CYC;
    localparam int unsigned CNT_W   = (CNT_MAX > 1)      ? $clog2(CNT_MAX)      : 1;
    localparam int unsigned STAB_W  = (LOCK_STABLE > 1)  ? $clog2(LOCK_STABLE)  : 1;
    localparam int unsigned TMO_W   = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam int unsigned CE_W    = (CE_DIV > 1)       ? $clog2(CE_DIV)       : 1;

    localparam logic [CNT_W-1:0]  PLL_RST_LAST = CNT_W'(PLL_RST_CYC - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST    = CNT_W'(HOLD_CYC - 1);
    localparam logic [STAB_W-1:0] STAB_LAST    = STAB_W'(LOCK_STABLE - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST     = TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [CE_W-1:0]   CE_LAST      = CE_W'(CE_DIV - 1);

    typedef enum logic [1:0] {
        S_PLL_RST   = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_HOLD      = 2'd2,
        S_RUN       = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic                sync1_q, lock_s_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [STAB_W-1:0]   stab_q, stab_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [CE_W-1:0]     ce_cnt_q, ce_cnt_d;
    logic [7:0]          fail_cnt_q, fail_cnt_d;
    logic                fail_evt;
    logic                pll_rst_q, pll_rst_d;
    logic                sys_rst_n_q, sys_rst_n_d;
    logic                cpu_ce_q, cpu_ce_d;
    logic                ready_q, ready_d;

    // Two-flop synchronizer for the asynchronous PLL lock
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            sync1_q  <= pll_locked;
            lock_s_q <= sync1_q;
        end
    end

    // State register
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_PLL_RST;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; fail_evt flags every lock failure that forces a retry
    always_comb begin
        state_d  = state_q;
        fail_evt = 1'b0;
        case (state_q)
            S_PLL_RST: begin
                if (cnt_q == PLL_RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: begin
                // a lock that becomes stable on the timeout cycle still wins
                if (lock_s_q && (stab_q == STAB_LAST)) begin
                    state_d = S_HOLD;
                end else if (tmo_q == TMO_LAST) begin
                    state_d  = S_PLL_RST;
                    fail_evt = 1'b1;
                end
            end
            S_HOLD: begin
                if (!lock_s_q) begin
                    state_d  = S_PLL_RST;
                    fail_evt = 1'b1;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!lock_s_q) begin
                    state_d  = S_PLL_RST;
                    fail_evt = 1'b1;
                end
            end
            default: begin
                state_d = S_PLL_RST;
            end
        endcase
    end

    // Counter next values; every counter restarts from zero on any state change
    always_comb begin
        cnt_d      = '0;
        stab_d     = '0;
        tmo_d      = '0;
        ce_cnt_d   = '0;
        fail_cnt_d = fail_cnt_q;
        if ((state_d == state_q) && ((state_q == S_PLL_RST) || (state_q == S_HOLD))) begin
            cnt_d = cnt_q + 1'b1;
        end
        if ((state_d == S_WAIT_LOCK) && (state_q == S_WAIT_LOCK)) begin
            tmo_d = tmo_q + 1'b1;
            if (lock_s_q) begin
                stab_d = stab_q + 1'b1;
            end
        end
        if ((state_d == S_RUN) && (state_q == S_RUN)) begin
            ce_cnt_d = (ce_cnt_q == CE_LAST) ? '0 : ce_cnt_q + 1'b1;
        end
        if (fail_evt && (fail_cnt_q != 8'hFF)) begin
            fail_cnt_d = fail_cnt_q + 8'd1;
        end
    end

    // Output decode from the upcoming state so every output is registered
    // yet changes on the same edge as the state itself. The strobe is taken
    // from the counter's terminal value one cycle late, so the first pulse
    // lands CE_DIV cycles after sys_rst_n rises; a lock loss kills it at once.
    always_comb begin
        pll_rst_d   = (state_d == S_PLL_RST);
        sys_rst_n_d = (state_d == S_RUN);
        ready_d     = (state_d == S_RUN);
        cpu_ce_d    = (state_d == S_RUN) &&
                      ((CE_DIV == 1) || ((state_q == S_RUN) && (ce_cnt_q == CE_LAST)));
    end

    // Counter and output registers
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            stab_q      <= '0;
            tmo_q       <= '0;
            ce_cnt_q    <= '0;
            fail_cnt_q  <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            cpu_ce_q    <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            stab_q      <= stab_d;
            tmo_q       <= tmo_d;
            ce_cnt_q    <= ce_cnt_d;
            fail_cnt_q  <= fail_cnt_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_n_q <= sys_rst_n_d;
            cpu_ce_q    <= cpu_ce_d;
            ready_q     <= ready_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst_n = sys_rst_n_q;
    assign cpu_ce    = cpu_ce_q;
    assign ready     = ready_q;
    assign fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_de0_rstseq.sv
// Directed bench for de0_rstseq with reduced timing parameters.
// Expected output vectors {pll_rst, sys_rst_n, cpu_ce, ready, fail_cnt}
// are queued as stimulus is applied and checked as the DUT responds.
module tb_de0_rstseq;

    logic       clkin = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       cpu_ce;
    logic       ready;
    logic [7:0] fail_cnt;

    typedef struct {
        string       tag;
        logic [11:0] v;
    } exp_t;

    exp_t        sbq[$];
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    de0_rstseq #(
        .PLL_RST_CYC (4),
        .LOCK_STABLE (8),
        .LOCK_TIMEOUT(32),
        .HOLD_CYC    (5),
        .CE_DIV      (3)
    ) dut (
        .clkin     (clkin),
        .rst_n     (rst_n),
        .pll_locked(pll_locked),
        .pll_rst   (pll_rst),
        .sys_rst_n (sys_rst_n),
        .cpu_ce    (cpu_ce),
        .ready     (ready),
        .fail_cnt  (fail_cnt)
    );

    always #5 clkin = ~clkin;

    function automatic logic [11:0] mk(input logic p, input logic s, input logic c,
                                       input logic r, input int unsigned f);
        logic [7:0] f8;
        f8 = (f > 255) ? 8'hFF : f[7:0];
        return {p, s, c, r, f8};
    endfunction

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clkin);
        #1;
    endtask

    task automatic push(input string tag, input logic [11:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sbq.push_back(e);
    endtask

    task automatic check_pop();
        exp_t        e;
        logic [11:0] obs;
        obs = {pll_rst, sys_rst_n, cpu_ce, ready, fail_cnt};
        vectors++;
        if (sbq.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty: observed %h required an entry", obs);
        end else begin
            e = sbq.pop_front();
            assert (obs === e.v) else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h (t=%0t)", e.tag, obs, e.v, $time);
            end
        end
    endtask

    task automatic now_expect(input string tag, input logic [11:0] v);
        push(tag, v);
        check_pop();
    endtask

    task automatic step_expect(input string tag, input logic [11:0] v);
        push(tag, v);
        tick(1);
        check_pop();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        pll_locked = 1'b1;
        tick(3);
        now_expect("reset_state", mk(1, 0, 0, 0, 0));

        // Power-up with lock present; release after edge 0
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) step_expect("t1_pllrst_hi", mk(1, 0, 0, 0, 0));
        step_expect("t1_pllrst_fall", mk(0, 0, 0, 0, 0));
        for (int i = 5; i <= 16; i++) step_expect("t1_wait_hold", mk(0, 0, 0, 0, 0));
        step_expect("t1_sysrst_rise", mk(0, 1, 0, 1, 0));
        for (int k = 0; k < 3; k++) begin
            step_expect("t1_run_idle", mk(0, 1, 0, 1, 0));
            step_expect("t1_run_idle", mk(0, 1, 0, 1, 0));
            step_expect("t1_cpu_ce", mk(0, 1, 1, 1, 0));
        end

        // Lock loss in RUN right after a strobe; next strobe must not appear
        pll_locked = 1'b0;
        step_expect("t4_drop_1", mk(0, 1, 0, 1, 0));
        step_expect("t4_drop_2", mk(0, 1, 0, 1, 0));
        step_expect("t4_drop_3", mk(1, 0, 0, 0, 1));
        pll_locked = 1'b1;
        for (int i = 0; i < 3; i++) step_expect("t4_re_pllrst", mk(1, 0, 0, 0, 1));
        for (int i = 0; i < 13; i++) step_expect("t4_re_wait_hold", mk(0, 0, 0, 0, 1));
        step_expect("t4_re_run", mk(0, 1, 0, 1, 1));
        step_expect("t4_re_run_idle", mk(0, 1, 0, 1, 1));
        step_expect("t4_re_run_idle", mk(0, 1, 0, 1, 1));
        step_expect("t4_re_cpu_ce", mk(0, 1, 1, 1, 1));

        // Asynchronous reset mid-cycle while in RUN
        #3;
        rst_n = 1'b0;
        #1;
        now_expect("t5_run_async_rst", mk(1, 0, 0, 0, 0));

        // Lock glitch during WAIT_LOCK restarts the stability window
        pll_locked = 1'b0;
        tick(2);
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) step_expect("t2_pllrst_hi", mk(1, 0, 0, 0, 0));
        pll_locked = 1'b1;
        step_expect("t2_wait_entry", mk(0, 0, 0, 0, 0));
        for (int i = 5; i <= 8; i++) step_expect("t2_wait", mk(0, 0, 0, 0, 0));
        pll_locked = 1'b0;
        step_expect("t2_glitch", mk(0, 0, 0, 0, 0));
        pll_locked = 1'b1;
        for (int i = 10; i <= 23; i++) step_expect("t2_delayed_hold", mk(0, 0, 0, 0, 0));
        step_expect("t2_run", mk(0, 1, 0, 1, 0));

        #3;
        rst_n = 1'b0;
        #1;
        now_expect("t2_async_rst", mk(1, 0, 0, 0, 0));

        // No lock at all: 36-cycle retry period, fail_cnt saturates
        pll_locked = 1'b0;
        tick(2);
        rst_n = 1'b1;
        for (int a = 0; a < 300; a++) begin
            tick(3);
            now_expect("t3_pllrst", mk(1, 0, 0, 0, a));
            step_expect("t3_pllrst_fall", mk(0, 0, 0, 0, a));
            tick(31);
            now_expect("t3_wait_end", mk(0, 0, 0, 0, a));
            step_expect("t3_retry", mk(1, 0, 0, 0, a + 1));
        end

        // Lock becomes stable exactly on the last timeout cycle: HOLD wins
        tick(3);
        step_expect("t6_wait_entry", mk(0, 0, 0, 0, 255));
        tick(22);
        pll_locked = 1'b1;
        tick(8);
        step_expect("t6_wait_last", mk(0, 0, 0, 0, 255));
        step_expect("t6_hold_entry", mk(0, 0, 0, 0, 255));
        step_expect("t6_hold", mk(0, 0, 0, 0, 255));

        // Asynchronous reset mid-cycle while in HOLD clears fail_cnt
        #3;
        rst_n = 1'b0;
        #1;
        now_expect("t5_hold_async_rst", mk(1, 0, 0, 0, 0));
        tick(1);
        now_expect("t5_reset_held", mk(1, 0, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
